seg_display_arb: RTL and testbench

SEG_DISPLAY_ARB -- requirements
Module: seg_display_arb

---
 rtl/seg_display_arb_pkg.sv | 33 +++
 rtl/seg_display_arb_scan_timer.sv | 45 ++++
 rtl/seg_display_arb.sv | 144 ++++++++++++++
 tb/tb_seg_display_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_arb_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_arb_pkg
// Shared definitions for the four-digit seven-segment score/message arbiter:
// display owner encoding, the blank nibble code, parameter defaults and a
// helper used for leading-zero suppression.
// -----------------------------------------------------------------------------
package seg_display_arb_pkg;

    // Who currently owns the display.
    typedef enum logic {
        SHOW_SCORE = 1'b0,
        SHOW_MSG   = 1'b1
    } state_t;

    // Message nibble that means "leave this digit dark".
    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam int PRESCALE_DEFAULT    = 50000;
    localparam int HOLD_FRAMES_DEFAULT = 250;

    // True when every score nibble at position idx and above is zero.
    function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] idx);
        logic z;
        z = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(idx) && v[i*4 +: 4] != 4'h0) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/seg_display_arb_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Free-running digit scan timebase: a prescaler counting 0..PRESCALE-1 and a
// 2-bit digit index that advances on each prescaler wrap.
//
// Ports
//   CLK        system clock
//   RST        synchronous active-high reset
//   tick       one-cycle pulse while the prescaler sits at PRESCALE-1
//   frame_end  tick on which the index wraps 3 -> 0
//   index      digit currently being scanned (0 = rightmost)
// -----------------------------------------------------------------------------
module scan_timer
    import seg_display_arb_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       tick,
    output logic       frame_end,
    output logic [1:0] index
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign tick      = (count == LAST);
    assign frame_end = tick && (index == 2'd3);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
            index <= 2'd0;
        end else if (tick) begin
            count <= '0;
            index <= index + 2'd1;   // natural 2-bit wrap 3 -> 0
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seg_display_arb.sv
// -----------------------------------------------------------------------------
// seg_display_arb
// Multiplexed four-digit display driver that normally shows a live BCD score
// and, on request, shows a captured message for HOLD_FRAMES full scan frames.
//
// Interface semantics: msg_req is a single-cycle strobe with no back-pressure;
// msg_bcd is sampled only in that cycle. A new request while a message is
// showing replaces it and restarts the hold. score_bcd is read live.
//
// Ports
//   CLK        system clock
//   RST        synchronous active-high reset
//   score_bcd  four BCD score digits, [3:0] = rightmost
//   msg_req    one-cycle request to show msg_bcd
//   msg_bcd    message digits, nibble 4'hF = blank
//   an         active-low digit anodes (registered)
//   digit      BCD value for the segment decoder (registered)
//   blank      current digit dark (registered)
//   busy       message owns the display (registered)
//   state_dbg  current owner state, for observation
// -----------------------------------------------------------------------------
module seg_display_arb
    import seg_display_arb_pkg::*;
#(
    parameter int PRESCALE    = PRESCALE_DEFAULT,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] score_bcd,
    input  logic        msg_req,
    input  logic [15:0] msg_bcd,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        busy,
    output state_t      state_dbg
);

    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [FW-1:0] HOLD_LOAD = FW'(HOLD_FRAMES);
    localparam logic [FW-1:0] ONE       = FW'(1);

    logic          tick;
    logic          frame_end;
    logic [1:0]    index;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [15:0]   msg_reg;

    logic [3:0]    an_n;
    logic [3:0]    digit_n;
    logic          blank_n;
    logic          busy_n;
    logic [3:0]    score_nib;
    logic [3:0]    msg_nib;

    scan_timer #(
        .PRESCALE (PRESCALE)
    ) u_scan_timer (
        .CLK       (CLK),
        .RST       (RST),
        .tick      (tick),
        .frame_end (frame_end),
        .index     (index)
    );

    assign state_dbg = state;

    // Display ownership. A request always wins over a coincident frame end,
    // so the hold count restarts cleanly from HOLD_FRAMES.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= SHOW_SCORE;
            frame_cnt <= '0;
            msg_reg   <= 16'hFFFF;
        end else begin
            case (state)
                SHOW_SCORE: begin
                    if (msg_req) begin
                        state     <= SHOW_MSG;
                        msg_reg   <= msg_bcd;
                        frame_cnt <= HOLD_LOAD;
                    end
                end
                SHOW_MSG: begin
                    if (msg_req) begin
                        msg_reg   <= msg_bcd;
                        frame_cnt <= HOLD_LOAD;
                    end else if (frame_end) begin
                        if (frame_cnt == ONE) begin
                            state     <= SHOW_SCORE;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt - ONE;
                        end
                    end
                end
            endcase
        end
    end

    // Next-value selection for the current digit slot.
    always_comb begin
        score_nib = score_bcd[{index, 2'b00} +: 4];
        msg_nib   = msg_reg[{index, 2'b00} +: 4];
        an_n      = ~(4'b0001 << index);
        digit_n   = 4'h0;
        blank_n   = 1'b1;
        busy_n    = 1'b0;
        if (state == SHOW_MSG) begin
            busy_n = 1'b1;
            if (msg_nib == BLANK_CODE) begin
                blank_n = 1'b1;
                digit_n = 4'h0;
            end else begin
                blank_n = 1'b0;
                digit_n = msg_nib;
            end
        end else begin
            digit_n = score_nib;
            // Non-BCD nibbles go dark; leading zeros are suppressed but
            // index 0 always lights so a zero score shows a single "0".
            blank_n = (score_nib > 4'd9) ||
                      ((index != 2'd0) && upper_zero(score_bcd, index));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            an    <= 4'b1111;
            digit <= 4'h0;
            blank <= 1'b1;
            busy  <= 1'b0;
        end else begin
            an    <= an_n;
            digit <= digit_n;
            blank <= blank_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_seg_display_arb.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arb
// Bench for seg_display_arb with PRESCALE=4, HOLD_FRAMES=2. The reference
// model works from elapsed cycles since reset: the scan index is
// (cycles / PRESCALE) % 4 and a message stays shown up to the HOLD_FRAMES-th
// frame boundary after its request.
// -----------------------------------------------------------------------------
module tb_seg_display_arb;
    import seg_display_arb_pkg::*;

    localparam int P = 4;
    localparam int H = 2;
    localparam int F = 4 * P;   // cycles per full scan frame

    // ---------------- clock / reset ----------------
    logic        CLK;
    logic        RST;
    logic [15:0] score_bcd;
    logic        msg_req;
    logic [15:0] msg_bcd;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        blank;
    logic        busy;
    state_t      state_dbg;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    seg_display_arb #(
        .PRESCALE    (P),
        .HOLD_FRAMES (H)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .score_bcd (score_bcd),
        .msg_req   (msg_req),
        .msg_bcd   (msg_bcd),
        .an        (an),
        .digit     (digit),
        .blank     (blank),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model ----------------
    int          cyc;        // edges since reset release
    bit          has_msg;
    int          msg_end;    // last edge at which the message still owns the display
    logic [15:0] msg_data;

    logic [9:0]  exp_q[$];   // {an, digit, blank, busy}
    logic        st_q[$];    // owner state right after the edge

    int total;
    int bad;

    function automatic logic [9:0] model_out(input logic [15:0] sc, input bit act,
                                             input logic [15:0] md, input int idx);
        logic [3:0] a;
        logic [3:0] d;
        logic [3:0] nib;
        logic       b;
        a = ~(4'(1) << idx);
        if (act) begin
            nib = md[idx*4 +: 4];
            if (nib == 4'hF) begin
                b = 1'b1;
                d = 4'h0;
            end else begin
                b = 1'b0;
                d = nib;
            end
        end else begin
            nib = sc[idx*4 +: 4];
            d   = nib;
            b   = (nib > 4'd9) || (idx > 0 && (sc >> (4 * idx)) == 16'h0000);
        end
        return {a, d, b, act};
    endfunction

    // First frame boundary strictly after edge c.
    function automatic int next_frame_end(input int c);
        int fe;
        fe = (c / F) * F + F - 1;
        if (fe <= c) fe += F;
        return fe;
    endfunction

    function automatic logic [15:0] rand_score();
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) s[i*4 +: 4] = 4'h0;
            else                           s[i*4 +: 4] = 4'($urandom_range(0, 11));
        end
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        logic [9:0] e;
        int         idx;
        bit         act;
        if (RST) begin
            e = {4'b1111, 4'h0, 1'b1, 1'b0};
        end else begin
            idx = (cyc / P) % 4;
            act = has_msg && (cyc <= msg_end);
            e   = model_out(score_bcd, act, msg_data, idx);
        end
        exp_q.push_back(e);
        @(posedge CLK);
        if (RST) begin
            cyc     = 0;
            has_msg = 1'b0;
        end else begin
            if (msg_req) begin
                has_msg  = 1'b1;
                msg_data = msg_bcd;
                msg_end  = next_frame_end(cyc) + (H - 1) * F;
            end
            cyc++;
        end
        st_q.push_back(has_msg && (cyc <= msg_end));
        @(negedge CLK);
    endtask

    task automatic pulse_msg(input logic [15:0] m);
        msg_req = 1'b1;
        msg_bcd = m;
        step();
        msg_req = 1'b0;
        msg_bcd = 16'($urandom());
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [9:0] e;
        logic       s;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({an, digit, blank, busy} !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t: got an=%b digit=%h blank=%b busy=%b, required an=%b digit=%h blank=%b busy=%b",
                             $time, an, digit, blank, busy, e[9:6], e[5:2], e[1], e[0]);
                end
            end
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                total++;
                if (state_dbg !== state_t'(s)) begin
                    bad++;
                    $display("FAIL state t=%0t: got %0d, required %0d", $time, state_dbg, s);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        has_msg   = 1'b0;
        msg_end   = 0;
        msg_data  = 16'hFFFF;
        RST       = 1'b1;
        msg_req   = 1'b1;      // request during reset must be ignored
        msg_bcd   = 16'h1234;
        score_bcd = 16'h0042;

        step();
        msg_req = 1'b0;
        step();
        step();
        RST = 1'b0;

        // Scan walk and leading-zero suppression.
        repeat (40) step();
        score_bcd = 16'h0000;
        repeat (16) step();
        score_bcd = 16'h00A5;
        repeat (16) step();
        score_bcd = 16'h1234;

        // Message hold, then a replacement landing on a frame boundary.
        pulse_msg(16'hF1F2);
        repeat (3) step();
        for (int k = 0; k < F && (cyc % F) != F - 1; k++) step();
        pulse_msg(16'h0007);
        repeat (50) step();

        // Reset in the middle of a message.
        pulse_msg(16'hF1F2);
        repeat (10) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        repeat (30) step();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) score_bcd = rand_score();
            RST = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) begin
                msg_req = 1'b1;
                msg_bcd = 16'($urandom());
            end else begin
                msg_req = 1'b0;
                msg_bcd = 16'($urandom());
            end
            step();
        end
        RST     = 1'b0;
        msg_req = 1'b0;
        repeat (4) step();

        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
